// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage : PC owner, 1-cycle imem requester, 2-entry decode queue
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_enable,
  output logic [ADDRESS_WIDTH-1:0] imem_address,
  input  logic [DATA_WIDTH-1:0]    imem_data,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_instruction,
  output logic [ADDRESS_WIDTH-1:0] out_pc
);

  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [ADDRESS_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                     inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0]    fifo_instr_q [2];
  logic [DATA_WIDTH-1:0]    fifo_instr_d [2];
  logic [ADDRESS_WIDTH-1:0] fifo_pc_q [2];
  logic [ADDRESS_WIDTH-1:0] fifo_pc_d [2];
  logic                     rd_ptr_q, rd_ptr_d;
  logic                     wr_ptr_q, wr_ptr_d;
  logic [1:0]               count_q, count_d;

  logic       pop;
  logic       push;
  logic       issue;
  logic [1:0] occupancy;
  logic       unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign out_valid       = (count_q != 2'd0) && !redirect_valid && !reset;
  assign pop             = out_valid && out_ready;
  assign push            = inflight_q && !redirect_valid;
  assign out_instruction = fifo_instr_q[rd_ptr_q];
  assign out_pc          = fifo_pc_q[rd_ptr_q];

  // Every outstanding request owns a queue slot, so responses always fit.
  assign occupancy    = count_q + {1'b0, inflight_q};
  assign issue        = !reset && !redirect_valid && (occupancy <= (2'd1 + {1'b0, pop}));
  assign imem_enable  = issue;
  assign imem_address = pc_q;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    fifo_instr_d  = fifo_instr_q;
    fifo_pc_d     = fifo_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q + {1'b0, push} - {1'b0, pop};

    if (issue) begin
      pc_d          = pc_q + ADDRESS_WIDTH'(4);
      inflight_pc_d = pc_q;
    end
    if (push) begin
      fifo_instr_d[wr_ptr_q] = imem_data;
      fifo_pc_d[wr_ptr_q]    = inflight_pc_q;
      wr_ptr_d               = !wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = !rd_ptr_q;
    end

    if (redirect_valid) begin
      pc_d     = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      for (int i = 0; i < 2; i++) begin
        fifo_instr_q[i] <= fifo_instr_d[i];
        fifo_pc_q[i]    <= fifo_pc_d[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage : directed bench for fetch_stage (32-bit and 8-bit address)
// Revision       : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Main instance: 32-bit addresses, RESET_PC = 0
  logic        reset, imem_enable, redirect_valid, out_valid, out_ready;
  logic [31:0] imem_address, imem_data, redirect_pc, out_instruction, out_pc;

  // Wrap instance: 8-bit addresses, RESET_PC = 0xF8
  logic        reset_b, imem_enable_b, out_valid_b;
  logic [7:0]  imem_address_b, out_pc_b;
  logic [31:0] imem_data_b, out_instruction_b;

  fetch_stage #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .imem_enable(imem_enable), .imem_address(imem_address),
    .imem_data(imem_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
    .out_pc(out_pc)
  );

  fetch_stage #(.DATA_WIDTH(32), .ADDRESS_WIDTH(8), .RESET_PC(8'hF8)) dut_b (
    .clk(clk), .reset(reset_b), .imem_enable(imem_enable_b), .imem_address(imem_address_b),
    .imem_data(imem_data_b), .redirect_valid(1'b0), .redirect_pc(8'h00),
    .out_valid(out_valid_b), .out_ready(1'b1), .out_instruction(out_instruction_b),
    .out_pc(out_pc_b)
  );

  // Word at byte address a: 0x00000013, 0x00100093, 0x00200113, ...
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h0000_0013 + (a >> 2) * 32'h0010_0080;
  endfunction

  // One-cycle-latency instruction memories
  always @(posedge clk) begin
    imem_data   <= imem_enable   ? word_at(imem_address) : 32'hDEAD_BEEF;
    imem_data_b <= imem_enable_b ? word_at({24'h0, imem_address_b}) : 32'hDEAD_BEEF;
  end

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; reset_b = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    tick();
    #1;
    checks++;
    if ({imem_enable, out_valid, out_pc, out_instruction} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_state: got en=%b v=%b pc=%h ins=%h, expected 0 0 0 0",
               imem_enable, out_valid, out_pc, out_instruction);
    end
    tick();
  endtask

  task automatic test_stream();
    logic [31:0] e;
    reset = 1'b0;
    #1;
    checks++;
    if ({imem_enable, imem_address, out_valid} !== {1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL first_request: got en=%b addr=%h v=%b, expected 1 0 0", imem_enable, imem_address, out_valid);
    end
    tick(); #1;
    checks++;
    if ({imem_enable, imem_address, out_valid} !== {1'b1, 32'h4, 1'b0}) begin
      errors++;
      $display("FAIL second_request: got en=%b addr=%h v=%b, expected 1 4 0", imem_enable, imem_address, out_valid);
    end
    tick();
    for (int k = 0; k < 6; k++) begin
      e = 32'(4 * k);
      #1;
      checks++;
      if ({out_valid, out_pc, out_instruction, imem_enable, imem_address} !==
          {1'b1, e, word_at(e), 1'b1, e + 32'd8}) begin
        errors++;
        $display("FAIL stream[%0d]: got v=%b pc=%h ins=%h en=%b addr=%h, expected 1 %h %h 1 %h",
                 k, out_valid, out_pc, out_instruction, imem_enable, imem_address, e, word_at(e), e + 32'd8);
      end
      tick();
    end
    // Mid-stream stall: head held, no further requests, no loss on release
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if ({out_valid, out_pc, out_instruction, imem_enable} !== {1'b1, 32'h18, word_at(32'h18), 1'b0}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%b pc=%h ins=%h en=%b, expected 1 18 %h 0",
                 k, out_valid, out_pc, out_instruction, imem_enable, word_at(32'h18));
      end
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e = 32'h18 + 32'(4 * k);
      #1;
      checks++;
      if ({out_valid, out_pc, out_instruction} !== {1'b1, e, word_at(e)}) begin
        errors++;
        $display("FAIL stall_release[%0d]: got v=%b pc=%h ins=%h, expected 1 %h %h",
                 k, out_valid, out_pc, out_instruction, e, word_at(e));
      end
      tick();
    end
  endtask

  task automatic test_stall_from_reset();
    reset = 1'b1; out_ready = 1'b0;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if ({imem_enable, out_valid, out_pc} !==
          {(c < 2), (c >= 2), 32'h0}) begin
        errors++;
        $display("FAIL stall_cycle[%0d]: got en=%b v=%b pc=%h, expected %b %b 0",
                 c, imem_enable, out_valid, out_pc, c < 2, c >= 2);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if ({out_valid, out_pc, out_instruction} !== {1'b1, 32'(4 * k), word_at(32'(4 * k))}) begin
        errors++;
        $display("FAIL stall_drain[%0d]: got v=%b pc=%h ins=%h, expected 1 %h %h",
                 k, out_valid, out_pc, out_instruction, 4 * k, word_at(32'(4 * k)));
      end
      tick();
    end
  endtask

  // Redirect while streaming (count=1, response in flight) to 0x40
  task automatic test_redirect_stream();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1;
    checks++;
    if ({out_valid, imem_enable} !== 2'b00) begin
      errors++;
      $display("FAIL redirect_cycle: got v=%b en=%b, expected 0 0", out_valid, imem_enable);
    end
    tick();
    redirect_valid = 1'b0; redirect_pc = '0;
    #1;
    checks++;
    if ({imem_enable, imem_address, out_valid} !== {1'b1, 32'h40, 1'b0}) begin
      errors++;
      $display("FAIL redirect_r1: got en=%b addr=%h v=%b, expected 1 40 0", imem_enable, imem_address, out_valid);
    end
    tick(); #1;
    checks++;
    if ({out_valid, imem_address} !== {1'b0, 32'h44}) begin
      errors++;
      $display("FAIL redirect_r2: got v=%b addr=%h, expected 0 44", out_valid, imem_address);
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if ({out_valid, out_pc, out_instruction} !== {1'b1, 32'h40 + 32'(4 * k), word_at(32'h40 + 32'(4 * k))}) begin
        errors++;
        $display("FAIL redirect_deliver[%0d]: got v=%b pc=%h ins=%h, expected 1 %h",
                 k, out_valid, out_pc, out_instruction, 32'h40 + 32'(4 * k));
      end
      tick();
    end
  endtask

  // Redirect to unaligned 0x43 with a full queue
  task automatic test_redirect_full();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({out_valid, out_pc} !== {1'b1, 32'h48}) begin
        errors++;
        $display("FAIL full_hold[%0d]: got v=%b pc=%h, expected 1 48", k, out_valid, out_pc);
      end
      tick();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h43; out_ready = 1'b1;
    #1;
    checks++;
    if ({out_valid, imem_enable} !== 2'b00) begin
      errors++;
      $display("FAIL full_redirect_cycle: got v=%b en=%b, expected 0 0", out_valid, imem_enable);
    end
    tick();
    redirect_valid = 1'b0; redirect_pc = '0;
    #1;
    checks++;
    if ({imem_enable, imem_address} !== {1'b1, 32'h40}) begin
      errors++;
      $display("FAIL unaligned_redirect: got en=%b addr=%h, expected 1 40", imem_enable, imem_address);
    end
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if ({out_valid, out_pc} !== {1'b1, 32'h40 + 32'(4 * k)}) begin
        errors++;
        $display("FAIL full_redirect_deliver[%0d]: got v=%b pc=%h, expected 1 %h",
                 k, out_valid, out_pc, 32'h40 + 32'(4 * k));
      end
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    tick(); tick();
    #1;
    checks++;
    if ({out_valid, out_pc} !== {1'b1, 32'h48}) begin
      errors++;
      $display("FAIL pre_reset_full: got v=%b pc=%h, expected 1 48", out_valid, out_pc);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, imem_enable, out_pc, out_instruction} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL async_reset: got v=%b en=%b pc=%h ins=%h, expected 0 0 0 0",
               out_valid, imem_enable, out_pc, out_instruction);
    end
    tick();
    reset = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if ({imem_enable, imem_address, out_valid} !== {1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL restart_request: got en=%b addr=%h v=%b, expected 1 0 0", imem_enable, imem_address, out_valid);
    end
    tick(); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL restart_no_old: got v=%b pc=%h, expected v=0", out_valid, out_pc);
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if ({out_valid, out_pc, out_instruction} !== {1'b1, 32'(4 * k), word_at(32'(4 * k))}) begin
        errors++;
        $display("FAIL restart_deliver[%0d]: got v=%b pc=%h ins=%h, expected 1 %h",
                 k, out_valid, out_pc, out_instruction, 4 * k);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_addr [5];
    exp_addr[0] = 8'hF8; exp_addr[1] = 8'hFC; exp_addr[2] = 8'h00;
    exp_addr[3] = 8'h04; exp_addr[4] = 8'h08;
    reset_b = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if ({imem_enable_b, imem_address_b} !== {1'b1, exp_addr[c]}) begin
        errors++;
        $display("FAIL wrap_addr[%0d]: got en=%b addr=%h, expected 1 %h", c, imem_enable_b, imem_address_b, exp_addr[c]);
      end
      if (c >= 2) begin
        checks++;
        if ({out_valid_b, out_pc_b, out_instruction_b} !==
            {1'b1, exp_addr[c-2], word_at({24'h0, exp_addr[c-2]})}) begin
          errors++;
          $display("FAIL wrap_out[%0d]: got v=%b pc=%h ins=%h, expected 1 %h",
                   c, out_valid_b, out_pc_b, out_instruction_b, exp_addr[c-2]);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_redirect_stream();
    test_redirect_full();
    test_reset_midstream();
    test_stall_from_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
